// File: rtl/risc_imem_loader.sv
// risc_imem_loader
//
// Boot-time instruction memory for risc_core. A program arrives as a byte
// stream (count byte N, then N 16-bit words high byte first, then an XOR
// checksum byte). While the program is loading the core is held in reset.
// Once the checksum matches, the core is released and instructions are
// served combinationally from the core's PC.
//
// Ports:
//   clk         single clock, all state changes on the rising edge
//   reset       synchronous, active-high
//   ld_valid    loader byte valid
//   ld_data     loader byte
//   ld_ready    this block accepts a byte this cycle
//   instr_addr  core PC (word address)
//   instr_data  instruction word to the core (combinational)
//   core_reset  reset for the core, high until the program is verified
//   load_done   program loaded and checksum matched
//   load_err    checksum mismatch, sticky until reset

module risc_imem_loader #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    input  logic [7:0]  instr_addr,
    output logic [15:0] instr_data,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        CSUM,
        RUN,
        ERR
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  wcount_q, wcount_d;
    logic [7:0]  waddr_q, waddr_d;
    logic [7:0]  hi_reg_q, hi_reg_d;
    logic [7:0]  xsum_q, xsum_d;
    logic        core_reset_q, core_reset_d;
    logic        load_done_q, load_done_d;
    logic        load_err_q, load_err_d;

    logic        accept;
    logic        mem_we;

    // Program storage; deliberately not reset, the read gating hides stale words.
    logic [15:0] mem [0:DEPTH-1];

    // Ready only in the loading states, and never while reset is held.
    always_comb begin
        ld_ready = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE, HI, LO, CSUM: ld_ready = 1'b1;
                default:            ld_ready = 1'b0;
            endcase
        end
    end

    assign accept = ld_valid && ld_ready;
    assign mem_we = accept && (state_q == LO);

    // Next-state and register updates; every register holds unless a byte is accepted.
    always_comb begin
        state_d      = state_q;
        wcount_d     = wcount_q;
        waddr_d      = waddr_q;
        hi_reg_d     = hi_reg_q;
        xsum_d       = xsum_q;
        core_reset_d = core_reset_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    // A count of zero stands for a full 256-word program.
                    wcount_d = (ld_data == 8'h00) ? 9'd256 : {1'b0, ld_data};
                    xsum_d   = ld_data;
                    waddr_d  = 8'h00;
                    state_d  = HI;
                end
                HI: begin
                    hi_reg_d = ld_data;
                    xsum_d   = xsum_q ^ ld_data;
                    state_d  = LO;
                end
                LO: begin
                    xsum_d  = xsum_q ^ ld_data;
                    // Wraps 255 -> 0 only on the last word of a 256-word load.
                    waddr_d = waddr_q + 8'd1;
                    if ({1'b0, waddr_q} == (wcount_q - 9'd1)) begin
                        state_d = CSUM;
                    end else begin
                        state_d = HI;
                    end
                end
                CSUM: begin
                    if (ld_data == xsum_q) begin
                        state_d      = RUN;
                        core_reset_d = 1'b0;
                        load_done_d  = 1'b1;
                    end else begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wcount_q     <= 9'd0;
            waddr_q      <= 8'd0;
            hi_reg_q     <= 8'd0;
            xsum_q       <= 8'd0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcount_q     <= wcount_d;
            waddr_q      <= waddr_d;
            hi_reg_q     <= hi_reg_d;
            xsum_q       <= xsum_d;
            core_reset_q <= core_reset_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    // Memory write; mem_we already excludes reset through ld_ready.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[waddr_q] <= {hi_reg_q, ld_data};
        end
    end

    // Only words of the verified program are ever visible to the core.
    always_comb begin
        instr_data = 16'h0000;
        if ((state_q == RUN) && ({1'b0, instr_addr} < wcount_q)) begin
            instr_data = mem[instr_addr];
        end
    end

    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_risc_imem_loader.sv
// tb_risc_imem_loader
//
// Bench for risc_imem_loader. A stream-level model (byte position within the
// program, expected memory image, load status) predicts every output and is
// compared with the DUT on each falling edge. Directed scenarios add literal
// expectations for the nominal program, bad checksum, throttling, full depth,
// reset mid-load and post-run hold.

module tb_risc_imem_loader;

    typedef logic [7:0] byte_q_t[$];

    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_ERR  = 2;

    logic        clk;
    logic        reset;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic [7:0]  instr_addr;
    logic [15:0] instr_data;
    logic        core_reset;
    logic        load_done;
    logic        load_err;

    int total;
    int bad;

    // Model state.
    logic [15:0] exp_mem [0:255];
    int          m_status;
    int          m_pos;
    int          m_n;
    logic [7:0]  m_xs;
    logic [7:0]  m_hi;
    bit          model_valid;

    byte_q_t nominal;
    byte_q_t stream;

    risc_imem_loader #(.DEPTH(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream-level model: tracks the position within the program, not the FSM.
    always @(posedge clk) begin
        if (reset) begin
            m_status    = M_LOAD;
            m_pos       = 0;
            m_n         = 0;
            m_xs        = 8'h00;
            model_valid = 1'b1;
        end else if (model_valid && ld_valid && m_status == M_LOAD) begin
            if (m_pos == 0) begin
                m_n  = (ld_data == 8'h00) ? 256 : int'(ld_data);
                m_xs = ld_data;
            end else if (m_pos <= 2 * m_n) begin
                m_xs = m_xs ^ ld_data;
                if (m_pos % 2 == 1) m_hi = ld_data;
                else exp_mem[m_pos / 2 - 1] = {m_hi, ld_data};
            end else begin
                m_status = (ld_data == m_xs) ? M_RUN : M_ERR;
            end
            m_pos++;
        end
    end

    function automatic logic [15:0] modelData(input logic [7:0] a);
        if (m_status == M_RUN && int'(a) < m_n) return exp_mem[a];
        return 16'h0000;
    endfunction

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("ld_ready",   {15'd0, ld_ready},   {15'd0, !reset && m_status == M_LOAD});
            checkOutput("core_reset", {15'd0, core_reset}, {15'd0, m_status != M_RUN});
            checkOutput("load_done",  {15'd0, load_done},  {15'd0, m_status == M_RUN});
            checkOutput("load_err",   {15'd0, load_err},   {15'd0, m_status == M_ERR});
            checkOutput("instr_data", instr_data, modelData(instr_addr));
        end
    end

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input byte_q_t bytes, input int maxGap);
        foreach (bytes[i]) begin
            if (maxGap > 0) begin
                repeat ($urandom_range(0, maxGap)) begin
                    ld_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            ld_valid = 1'b1;
            ld_data  = bytes[i];
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
    endtask

    task automatic readAt(input logic [7:0] a, input string name, input logic [15:0] exp);
        instr_addr = a;
        @(negedge clk); #1;
        checkOutput(name, instr_data, exp);
    endtask

    task automatic checkNominalImage();
        readAt(8'd0, "nom_addr0", 16'h2108);
        readAt(8'd1, "nom_addr1", 16'h2209);
        readAt(8'd2, "nom_addr2", 16'h006C);
        readAt(8'd3, "nom_addr3", 16'h330A);
        readAt(8'd4, "nom_addr4", 16'h0000);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        model_valid = 1'b0;
        reset       = 1'b1;
        ld_valid    = 1'b0;
        ld_data     = 8'h00;
        instr_addr  = 8'h00;
        nominal = '{8'h04, 8'h21, 8'h08, 8'h22, 8'h09, 8'h00, 8'h6C, 8'h33, 8'h0A, 8'h53};

        // Reset state.
        @(posedge clk); #1;
        @(negedge clk); #1;
        checkOutput("rst_ready_low", {15'd0, ld_ready}, 16'h0000);
        reset = 1'b0;
        @(negedge clk); #1;
        checkOutput("rst_ready",      {15'd0, ld_ready},   16'h0001);
        checkOutput("rst_core_reset", {15'd0, core_reset}, 16'h0001);
        checkOutput("rst_done",       {15'd0, load_done},  16'h0000);
        checkOutput("rst_instr",      instr_data,          16'h0000);

        // Nominal load, back-to-back bytes.
        $display("[TB] nominal load");
        applyStimulus(nominal, 0);
        @(negedge clk); #1;
        checkOutput("nom_done",       {15'd0, load_done},  16'h0001);
        checkOutput("nom_core_reset", {15'd0, core_reset}, 16'h0000);
        checkNominalImage();

        // Bad checksum, then bytes that must be ignored.
        $display("[TB] bad checksum");
        doReset();
        stream = nominal;
        stream[9] = 8'h52;
        applyStimulus(stream, 0);
        applyStimulus(nominal, 0);
        instr_addr = 8'd0;
        @(negedge clk); #1;
        checkOutput("err_flag",       {15'd0, load_err},   16'h0001);
        checkOutput("err_core_reset", {15'd0, core_reset}, 16'h0001);
        checkOutput("err_ready",      {15'd0, ld_ready},   16'h0000);
        checkOutput("err_instr",      instr_data,          16'h0000);

        // Throttled source.
        $display("[TB] throttled load");
        doReset();
        applyStimulus(nominal, 3);
        @(negedge clk); #1;
        checkOutput("thr_done", {15'd0, load_done}, 16'h0001);
        checkNominalImage();

        // Full depth: word i = {i, ~i}; each pair XORs to FF, 256 pairs cancel, count 00 -> checksum 00.
        $display("[TB] full depth load");
        doReset();
        stream = {};
        stream.push_back(8'h00);
        for (int i = 0; i < 256; i++) begin
            stream.push_back(8'(i));
            stream.push_back(~8'(i));
        end
        stream.push_back(8'h00);
        applyStimulus(stream, 0);
        @(negedge clk); #1;
        checkOutput("full_done", {15'd0, load_done}, 16'h0001);
        readAt(8'd255, "full_addr255", 16'hFF00);
        readAt(8'd0,   "full_addr0",   16'h00FF);
        for (int a = 0; a < 256; a++) begin
            instr_addr = 8'(a);
            @(negedge clk); #1;
            checkOutput("full_nonzero", {15'd0, instr_data != 16'h0000}, 16'h0001);
        end

        // Reset mid-load, then a complete nominal load.
        $display("[TB] reset mid-load");
        doReset();
        stream = nominal[0:4];
        applyStimulus(stream, 0);
        @(negedge clk); #1;
        checkOutput("mid_core_reset", {15'd0, core_reset}, 16'h0001);
        doReset();
        applyStimulus(nominal, 0);
        @(negedge clk); #1;
        checkOutput("mid_done", {15'd0, load_done}, 16'h0001);
        checkNominalImage();

        // Post-run hold: arbitrary bytes with valid high change nothing.
        $display("[TB] post-run hold");
        stream = {};
        for (int i = 0; i < 20; i++) stream.push_back(8'($urandom_range(0, 255)));
        applyStimulus(stream, 0);
        @(negedge clk); #1;
        checkOutput("hold_done",  {15'd0, load_done}, 16'h0001);
        checkOutput("hold_ready", {15'd0, ld_ready},  16'h0000);
        checkNominalImage();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/risc_imem_loader.md
# risc_imem_loader

Boot-time instruction memory for `risc_core`. Receives a program as a byte stream over a valid/ready handshake and verifies an XOR checksum. Holds the core in reset while loading, then serves `instr_data` combinationally from the core's `instr_addr`. Sits directly upstream of the core's instruction port.

## Interface
- `DEPTH`, 256: instruction words; address width fixed at 8 bits.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `ld_valid`  in  1  loader byte valid.
- `ld_data`  in  8  loader byte.
- `ld_ready`  out  1  block accepts byte this cycle.
- `instr_addr`  in  8  core PC.
- `instr_data`  out  16  instruction word to core, combinational.
- `core_reset`  out  1  drive to core `reset`; high until program verified.
- `load_done`  out  1  program loaded and checksum matched.
- `load_err`  out  1  checksum mismatch; sticky until `reset`.

## Operation
- Byte transfer: a byte is accepted on a rising edge where `ld_valid && ld_ready`. No other edge consumes a byte.
- `ld_ready` = 1 in IDLE, HI, LO and CSUM. It is 0 in RUN and ERR, and 0 while `reset` is high.
- Stream format: count byte N, then N words as 2N bytes (high byte first), then one checksum byte.
  - N = 0 encodes 256 words; the count is held internally as 9 bits.
- Checksum = XOR of the count byte and all 2N data bytes.
- Registers:
  - `wcount[8:0]`: word count N.
  - `waddr[7:0]`: write pointer.
  - `hi_reg[7:0]`: buffered high byte.
  - `xsum[7:0]`: running XOR.
- States and transitions:
  - IDLE: accept count → `wcount` = (byte==0 ? 256 : byte), `xsum` = byte, `waddr` = 0 → HI.
  - HI: accept → `hi_reg` = byte, `xsum` ^= byte → LO.
  - LO: accept → `mem[waddr]` = {`hi_reg`, byte}, `xsum` ^= byte, `waddr`++. Go to CSUM if `waddr` == `wcount`-1 before the increment, else HI.
  - CSUM: accept → RUN if byte == `xsum`, else ERR.
  - RUN: terminal until `reset`; ignores `ld_valid`.
  - ERR: terminal until `reset`; ignores `ld_valid`.
- Read path:
  - In RUN, `instr_data` = `mem[instr_addr]` when `instr_addr` < `wcount`, else 16'h0000.
  - In all other states `instr_data` = 16'h0000.
- `waddr` wraps 255→0 only on the final word of a 256-word load; no write occurs beyond it.
- Memory is not cleared by `reset`. The read-path gating guarantees stale contents are never visible.

## Timing
- Reset values (cycle after an edge with `reset`=1):
  - state IDLE; `wcount`, `waddr`, `hi_reg`, `xsum` = 0.
  - `core_reset` = 1, `load_done` = 0, `load_err` = 0.
  - `instr_data` = 0; `ld_ready` = 1 once `reset` falls.
- Throughput: one byte per cycle sustained; `ld_ready` never deasserts mid-stream.
- Latency: checksum byte accepted at edge k gives, from edge k onward:
  - on match: `core_reset` = 0, `load_done` = 1, and `instr_data` valid for the current `instr_addr`.
  - on mismatch: `load_err` = 1 and `core_reset` stays 1.
- `core_reset`, `load_done` and `load_err` are registered; no combinational path from `ld_*` to them.
- A word written at edge k is readable in RUN from edge k onward (write-before-read is irrelevant, since RUN follows CSUM).
- Reset mid-load or in RUN/ERR: returns to IDLE on the next edge. The partial program is discarded, `core_reset` = 1, and the next byte is taken as a count.
- `ld_valid` low in any state: hold state and all registers.

## Test plan
- Nominal load:
  - Stimulus: bytes 04, 21,08, 22,09, 00,6C, 33,0A, checksum 53.
  - Required: `load_done` = 1 and `core_reset` = 0 from the 10th accepted edge.
  - `instr_addr` 0..3 → 2108, 2209, 006C, 330A; `instr_addr` = 4 → 0000.
- Bad checksum: same stream with checksum 52 → `load_err` = 1, `core_reset` = 1, `ld_ready` = 0, `instr_data` = 0000; further bytes ignored.
- Throttled source: random `ld_valid` gaps (0–3 idle cycles) on the nominal stream → identical memory contents and result. No byte is lost or duplicated.
- Full depth: count 00, 256 words with word i = {i, ~i}, correct XOR checksum.
  - Required: `load_done` = 1 and `mem[255]` = FF00; every address reads non-zero.
- Reset mid-load: assert `reset` for 1 cycle after 5 bytes of the nominal stream, then send the full nominal stream.
  - Required: `core_reset` stays 1 throughout the first attempt; final result matches the nominal load.
- Post-run hold: after a nominal load, drive `ld_valid` = 1 with arbitrary bytes for 20 cycles → memory, `load_done` and `ld_ready` = 0 unchanged.
